cache_ctrl: RTL and testbench
=============================

# cache_ctrl

Single-port, write-back, write-allocate cache controller that sequences one direct-mapped cache data/tag array for a core load/store port. It accepts one CPU request at a time, resolves hits in the array, and on a miss performs dirty-victim writeback and line refill over an Avalon-MM style memory master. It sits between the core memory stage and the system bus.

## Interface
- CACHE_LINE_SIZE, 4: line size in bytes; only 4 supported (one 32-bit word per line).
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_read / cpu_write  in  1  request strobes, mutually exclusive.
- cpu_address  in  32  byte address.
- cpu_writedata  in  32  store data.
- cpu_byteenable  in  4  store byte lanes.
- cpu_waitrequest  out  1  high = request not accepted.
- cpu_readdata  out  32  load data.
- cpu_readdatavalid  out  1  one-cycle load-response pulse.
- cache_address  out  32  array lookup address.
- cache_write  out  1  array write on hit.
- cache_writedata  out  32  merged store word.
- cache_readdata  in  32  array data, registered: reflects cache_address of the previous cycle.
- cache_hit / cache_valid / cache_dirty  in  1  combinational status for cache_address.
- cache_victim_address  in  32  line address of the resident line at cache_address's index.
- cache_fill  out  1  array refill strobe (sets valid, clears dirty, writes tag).
- cache_fill_address  out  32  refill line address.
- cache_fill_data  out  32  refill word.
- mem_read / mem_write  out  1  bus strobes.
- mem_address  out  32  word-aligned bus address.
- mem_writedata  out  32  writeback data.
- mem_byteenable  out  4  always 4'hF.
- mem_waitrequest  in  1  bus stall.
- mem_readdata  in  32  bus read data.
- mem_readdatavalid  in  1  bus read response.

## Operation
- States: IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, REFILL (3-bit encoding).
- cache_address = cpu_address in IDLE, else latched req_address.
- cpu_waitrequest = 0 only in IDLE; request with cpu_read|cpu_write in IDLE is accepted: latch address, writedata, byteenable, op; go LOOKUP.
- LOOKUP:
  - hit & read: cpu_readdatavalid=1, cpu_readdata=cache_readdata; go IDLE.
  - hit & write: cache_write=1, cache_writedata byte i = be[i] ? req_writedata byte i : cache_readdata byte i; go IDLE.
  - miss & valid & dirty: latch cache_victim_address and cache_readdata into wb regs; go WB.
  - miss otherwise: go FILL_REQ.
- WB: mem_write=1, mem_address=wb address, mem_writedata=wb data; hold until mem_waitrequest=0, then FILL_REQ.
- FILL_REQ: mem_read=1, mem_address={req_address[31:2],2'b00}; hold until mem_waitrequest=0, then FILL_WAIT.
- FILL_WAIT: on mem_readdatavalid: cache_fill=1, cache_fill_address=req line, cache_fill_data=mem_readdata; go REFILL.
- REFILL: one bubble so cache_readdata reflects filled word; go LOOKUP (replay, now guaranteed hit; write-miss then sets dirty via hit-write).
- cache_write and cache_fill never asserted in the same cycle.

## Timing
- Reset (async, any state): state=IDLE, cpu_waitrequest=0, cpu_readdatavalid=0, cpu_readdata=0, mem_read=mem_write=0, cache_write=cache_fill=0, latched regs 0. Outstanding bus transaction is abandoned; a stray mem_readdatavalid in IDLE is ignored.
- Read hit: accept cycle 0, readdatavalid cycle 1; max throughput one request per 2 cycles.
- Write hit: accept cycle 0, array write at end of cycle 1.
- Clean miss, zero-wait bus, read latency L (readdatavalid L cycles after accept): FILL_REQ cycle 2, fill cycle 2+L, REFILL 3+L, response cycle 4+L.
- Dirty miss adds one WB cycle per zero-wait write plus stall cycles.
- mem_address/mem_writedata stable while mem_read/mem_write held under waitrequest.
- cpu inputs ignored outside IDLE.

## Test plan
- Cold read 0x0000_0100, L=1, memory word 0xDEADBEEF -> mem_read cycle 2 addr 0x100, fill cycle 3, cpu_readdatavalid cycle 5 with 0xDEADBEEF; second read same address -> valid 1 cycle after accept, no bus activity.
- Write hit 0x100 data 0x11223344 be 4'b0101 over line 0xDEADBEEF -> cache_writedata 0xDE22BE44; subsequent read returns 0xDE22BE44.
- Dirty conflict: after previous, read 0x0000_1100 (same index, depth 32) -> mem_write addr 0x100 data 0xDE22BE44, then mem_read addr 0x1100, response carries fetched word.
- Write miss clean 0x200 be 4'hF data 0xCAFEF00D -> fill, REFILL, LOOKUP hit-write; array dirty, later eviction writes 0xCAFEF00D.
- mem_waitrequest held 3 cycles in WB and FILL_REQ -> strobes and address stable, cpu_waitrequest high throughout, no duplicate fill.
- rst_n low during FILL_WAIT -> all outputs at reset values immediately; late mem_readdatavalid produces no cache_fill; next request serviced normally.

Source files
------------

// File: rtl/cache_ctrl.sv
// cache_ctrl: single-port, write-back, write-allocate controller for one
// direct-mapped data/tag array. It serves one core load/store at a time.
// Misses write back a dirty victim first, then refill the line over an
// Avalon-MM style master.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   cpu_*                  core request (read/write strobes, address, data,
//                          byte enables), waitrequest, load response
//   cache_address          array lookup address (live cpu_address in IDLE)
//   cache_write/_writedata hit-store into the array (byte-merged word)
//   cache_readdata         array data, one cycle after cache_address
//   cache_hit/_valid/_dirty/_victim_address  array status for cache_address
//   cache_fill/_fill_*     refill strobe, line address and word
//   mem_*                  bus master (read/write, address, data, byteenable,
//                          waitrequest, readdata, readdatavalid)
module cache_ctrl #(
  parameter int CACHE_LINE_SIZE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_address,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic        cpu_waitrequest,
  output logic [31:0] cpu_readdata,
  output logic        cpu_readdatavalid,
  output logic [31:0] cache_address,
  output logic        cache_write,
  output logic [31:0] cache_writedata,
  input  logic [31:0] cache_readdata,
  input  logic        cache_hit,
  input  logic        cache_valid,
  input  logic        cache_dirty,
  input  logic [31:0] cache_victim_address,
  output logic        cache_fill,
  output logic [31:0] cache_fill_address,
  output logic [31:0] cache_fill_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic        mem_readdatavalid
);

  localparam int OFS = $clog2(CACHE_LINE_SIZE);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, REFILL} state_t;

  state_t      state;
  logic [31:0] req_address, req_writedata, wb_address, wb_data;
  logic [3:0]  req_byteenable;
  logic        req_write;
  logic [31:0] line_address, merged;

  assign line_address = {req_address[31:OFS], {OFS{1'b0}}};

  // Store merge: enabled lanes come from the request, the rest from the array.
  always_comb begin
    merged = cache_readdata;
    for (int i = 0; i < 4; i++)
      if (req_byteenable[i]) merged[8*i +: 8] = req_writedata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      req_address    <= '0;
      req_writedata  <= '0;
      req_byteenable <= '0;
      req_write      <= 1'b0;
      wb_address     <= '0;
      wb_data        <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_read || cpu_write) begin
          req_address    <= cpu_address;
          req_writedata  <= cpu_writedata;
          req_byteenable <= cpu_byteenable;
          req_write      <= cpu_write;
          state          <= LOOKUP;
        end
        LOOKUP: begin
          if (cache_hit) state <= IDLE;
          else if (cache_valid && cache_dirty) begin
            // cache_readdata already holds the victim word for this index
            wb_address <= cache_victim_address;
            wb_data    <= cache_readdata;
            state      <= WB;
          end else state <= FILL_REQ;
        end
        WB:        if (!mem_waitrequest) state <= FILL_REQ;
        FILL_REQ:  if (!mem_waitrequest) state <= FILL_WAIT;
        FILL_WAIT: if (mem_readdatavalid) state <= REFILL;
        // Bubble so the array read reflects the filled word; the replay
        // through LOOKUP is then a guaranteed hit.
        REFILL:    state <= LOOKUP;
        default:   state <= IDLE;
      endcase
    end
  end

  // Outputs decode the state together with the array's same-cycle status, so
  // a hit answers in the LOOKUP cycle itself rather than one cycle later.
  always_comb begin
    cpu_waitrequest   = (state != IDLE);
    cpu_readdata      = '0;
    cpu_readdatavalid = 1'b0;
    cache_address     = (state == IDLE) ? cpu_address : req_address;
    cache_write       = 1'b0;
    cache_writedata   = merged;
    cache_fill        = 1'b0;
    cache_fill_address = line_address;
    cache_fill_data   = mem_readdata;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_address       = '0;
    mem_writedata     = '0;
    mem_byteenable    = 4'hF;
    case (state)
      LOOKUP: if (cache_hit) begin
        if (req_write) cache_write = 1'b1;
        else begin
          cpu_readdatavalid = 1'b1;
          cpu_readdata      = cache_readdata;
        end
      end
      WB: begin
        mem_write     = 1'b1;
        mem_address   = wb_address;
        mem_writedata = wb_data;
      end
      FILL_REQ: begin
        mem_read    = 1'b1;
        mem_address = line_address;
      end
      FILL_WAIT: cache_fill = mem_readdatavalid;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: behavioural direct-mapped array (32 lines), a bus
// memory with configurable read latency and waitrequest stalls, and a
// scoreboard of expected load responses, hit-writes and writebacks.
module tb_cache_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_read = 0, cpu_write = 0;
  logic [31:0] cpu_address = 0, cpu_writedata = 0;
  logic [3:0]  cpu_byteenable = 0;
  logic        cpu_waitrequest, cpu_readdatavalid;
  logic [31:0] cpu_readdata, cache_address, cache_writedata, cache_readdata;
  logic        cache_write, cache_hit, cache_valid, cache_dirty, cache_fill;
  logic [31:0] cache_victim_address, cache_fill_address, cache_fill_data;
  logic        mem_read, mem_write, mem_waitrequest;
  logic [31:0] mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_readdata = 0;
  logic        mem_readdatavalid = 0;

  cache_ctrl #(.CACHE_LINE_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .cpu_readdatavalid(cpu_readdatavalid),
    .cache_address(cache_address), .cache_write(cache_write),
    .cache_writedata(cache_writedata), .cache_readdata(cache_readdata),
    .cache_hit(cache_hit), .cache_valid(cache_valid), .cache_dirty(cache_dirty),
    .cache_victim_address(cache_victim_address), .cache_fill(cache_fill),
    .cache_fill_address(cache_fill_address), .cache_fill_data(cache_fill_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
    .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid)
  );

  // ---------------- array model: index addr[6:2], tag addr[31:7]
  logic [31:0] c_data [32];
  logic [24:0] c_tag  [32];
  logic [31:0] c_valid = '0, c_dirty = '0;
  logic [4:0]  a_idx, f_idx;
  assign a_idx = cache_address[6:2];
  assign f_idx = cache_fill_address[6:2];
  assign cache_valid = c_valid[a_idx];
  assign cache_dirty = c_dirty[a_idx];
  assign cache_hit   = c_valid[a_idx] && (c_tag[a_idx] == cache_address[31:7]);
  assign cache_victim_address = {c_tag[a_idx], a_idx, 2'b00};

  always @(posedge clk) begin
    cache_readdata <= c_data[a_idx];
    if (cache_fill) begin
      c_data[f_idx]  <= cache_fill_data;
      c_tag[f_idx]   <= cache_fill_address[31:7];
      c_valid[f_idx] <= 1'b1;
      c_dirty[f_idx] <= 1'b0;
    end
    if (cache_write) begin
      c_data[a_idx]  <= cache_writedata;
      c_dirty[a_idx] <= 1'b1;
    end
  end

  // ---------------- bus memory model
  int cyc = 0, lat_cfg = 1, stall_cfg = 0, stall_left = 0;
  typedef struct { logic [31:0] d; int due; } resp_t;
  resp_t rq_bus[$];
  logic [31:0] bus_mem [logic [31:0]];
  assign mem_waitrequest = (mem_read || mem_write) && (stall_left != 0);

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (bus_mem.exists(a)) return bus_mem[a];
    if (a == 32'h100) return 32'hDEADBEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- scoreboard
  typedef struct { logic [31:0] d; int acc; int lat; } rexp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wexp_t;
  rexp_t       rd_q[$];
  logic [31:0] cw_q[$];
  wexp_t       wb_q[$];
  int tests = 0, fails = 0, fill_cnt = 0, bus_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;
    logic [31:0] exp_rd; int exp_lat;
    bit exp_cw; logic [31:0] exp_cwd;
    bit exp_wb; logic [31:0] wb_addr; logic [31:0] wb_data;
    int fills; int stall;
  } vec_t;

  task automatic do_vec(input vec_t v);
    int n, acc;
    stall_cfg = v.stall;
    fill_cnt = 0;
    bus_cnt = 0;
    @(negedge clk);
    chk("accept_ready", 32'(cpu_waitrequest), 32'd0);
    cpu_read = !v.wr; cpu_write = v.wr;
    cpu_address = v.addr; cpu_writedata = v.wdata; cpu_byteenable = v.be;
    acc = cyc;
    if (!v.wr) rd_q.push_back('{v.exp_rd, acc, v.exp_lat});
    if (v.exp_cw) cw_q.push_back(v.exp_cwd);
    if (v.exp_wb) wb_q.push_back('{v.wb_addr, v.wb_data});
    @(posedge clk); #1;
    cpu_read = 0; cpu_write = 0;
    cpu_address = 32'hFFFF_FFF0; cpu_writedata = 32'h0BAD_0BAD; // ignored outside IDLE
    n = 0;
    do begin @(negedge clk); n++; end
    while ((cpu_waitrequest || rd_q.size() != 0) && n < 100);
    chk("done_in_time", 32'(n < 100), 32'd1);
    chk("fills", 32'(fill_cnt), 32'(v.fills));
    chk("bus_xfers", 32'(bus_cnt), 32'(v.fills + int'(v.exp_wb)));
    chk("sb_empty", 32'(rd_q.size() + cw_q.size() + wb_q.size()), 32'd0);
    rd_q.delete(); cw_q.delete(); wb_q.delete();
  endtask

  vec_t tbl [12];
  vec_t v_again;

  initial begin
    bit prev_stall, prev_r, prev_w, saw_rdv;
    logic [31:0] prev_a, prev_d;
    int n;

    tbl[0]  = '{0, 32'h100,  0, 4'h0, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0, 1, 0};
    tbl[1]  = '{0, 32'h100,  0, 4'h0, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 32'h100,  32'h11223344, 4'b0101, 0, 0, 1, 32'hDE22BE44, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 32'h100,  0, 4'h0, 32'hDE22BE44, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 32'h1100, 0, 4'h0, 32'h5A5A1100, 6, 0, 0, 1, 32'h100, 32'hDE22BE44, 1, 0};
    tbl[5]  = '{1, 32'h200,  32'hCAFEF00D, 4'hF, 0, 0, 1, 32'hCAFEF00D, 0, 0, 0, 1, 0};
    tbl[6]  = '{0, 32'h200,  0, 4'h0, 32'hCAFEF00D, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 32'h300,  0, 4'h0, 32'h5A5A0300, 6, 0, 0, 1, 32'h200, 32'hCAFEF00D, 1, 0};
    tbl[8]  = '{0, 32'h104,  0, 4'h0, 32'h5A5A0104, 5, 0, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{1, 32'h104,  32'hAABBCCDD, 4'b1000, 0, 0, 1, 32'hAA5A0104, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 32'h1104, 0, 4'h0, 32'h5A5A1104, 12, 0, 0, 1, 32'h104, 32'hAA5A0104, 1, 3};
    tbl[11] = '{0, 32'h1104, 0, 4'h0, 32'h5A5A1104, 1, 0, 0, 0, 0, 0, 0, 3};
    v_again = '{0, 32'h408,  0, 4'h0, 32'h5A5A0408, 5, 0, 0, 0, 0, 0, 1, 0};

    fork
      // bus: accept on a non-stalled strobe, answer reads lat_cfg cycles later
      forever begin
        bit dec, reload;
        dec = 0; reload = 0;
        @(negedge clk);
        if (rst_n && (mem_read || mem_write)) begin
          if (stall_left > 0) dec = 1;
          else begin
            bus_cnt++;
            reload = 1;
            if (mem_read) rq_bus.push_back('{rd_mem(mem_address), cyc + lat_cfg});
            else bus_mem[mem_address] = mem_writedata;
          end
        end else stall_left = stall_cfg;
        @(posedge clk);
        cyc++;
        #1;
        if (dec) stall_left--;
        if (reload) stall_left = stall_cfg;
        mem_readdatavalid = 0;
        while (rq_bus.size() != 0 && rq_bus[0].due < cyc) void'(rq_bus.pop_front());
        if (rq_bus.size() != 0 && rq_bus[0].due == cyc) begin
          mem_readdatavalid = 1;
          mem_readdata = rq_bus[0].d;
          void'(rq_bus.pop_front());
        end
      end
      // monitor
      forever begin
        @(negedge clk);
        if (rst_n) begin
          if (cpu_readdatavalid) begin
            if (rd_q.size() == 0) chk("rsp_unexpected", cpu_readdata, 32'hxxxx_xxxx);
            else begin
              rexp_t e;
              e = rd_q.pop_front();
              chk("rsp_data", cpu_readdata, e.d);
              chk("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
          end
          if (cache_fill) fill_cnt++;
          if (cache_write) begin
            chk("write_fill_excl", 32'(cache_fill), 32'd0);
            if (cw_q.size() == 0) chk("cwrite_unexpected", cache_writedata, 32'hxxxx_xxxx);
            else chk("cache_writedata", cache_writedata, cw_q.pop_front());
          end
          if (mem_write && !mem_waitrequest) begin
            if (wb_q.size() == 0) chk("wb_unexpected", mem_address, 32'hxxxx_xxxx);
            else begin
              wexp_t w;
              w = wb_q.pop_front();
              chk("wb_addr", mem_address, w.a);
              chk("wb_data", mem_writedata, w.d);
            end
          end
          if (prev_stall) begin
            chk("stall_read_held", 32'(mem_read), 32'(prev_r));
            chk("stall_write_held", 32'(mem_write), 32'(prev_w));
            chk("stall_addr_held", mem_address, prev_a);
            chk("stall_data_held", mem_writedata, prev_d);
          end
          if (mem_read || mem_write) chk("cpu_wait_busy", 32'(cpu_waitrequest), 32'd1);
          prev_stall = (mem_read || mem_write) && mem_waitrequest;
          prev_r = mem_read; prev_w = mem_write;
          prev_a = mem_address; prev_d = mem_writedata;
        end else prev_stall = 0;
      end
    join_none

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_waitrequest", 32'(cpu_waitrequest), 32'd0);
    chk("rst_rdvalid", 32'(cpu_readdatavalid), 32'd0);
    chk("rst_readdata", cpu_readdata, 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_cache_write", 32'(cache_write), 32'd0);
    chk("rst_cache_fill", 32'(cache_fill), 32'd0);
    chk("mem_byteenable", 32'(mem_byteenable), 32'hF);
    rst_n = 1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) do_vec(tbl[i]);

    // reset while waiting on a refill with a long read latency
    stall_cfg = 0;
    lat_cfg = 5;
    @(negedge clk);
    cpu_read = 1; cpu_address = 32'h408;
    @(posedge clk); #1;
    cpu_read = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(mem_read && !mem_waitrequest) && n < 20);
    chk("abort_fill_req_seen", 32'(n < 20), 32'd1);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("abort_waitrequest", 32'(cpu_waitrequest), 32'd0);
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_cache_fill", 32'(cache_fill), 32'd0);
    chk("abort_rdvalid", 32'(cpu_readdatavalid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    fill_cnt = 0;
    saw_rdv = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_readdatavalid) saw_rdv = 1;
    end
    chk("stray_rdv_seen", 32'(saw_rdv), 32'd1);
    chk("stray_no_fill", 32'(fill_cnt), 32'd0);
    lat_cfg = 1;
    do_vec(v_again);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
